// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the RV32 fetch stage with configurable branch-resolution latency.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_seq_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RESOLVE_LAT  = 1,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            hold,
  input  logic [6:0]      OP,
  input  logic            b_taken,
  input  logic [XLEN-1:0] up_amt,
  output logic [XLEN-1:0] IP,
  output logic [XLEN-1:0] PC_def,
  output logic            fetch_valid,
  output logic            busy,
  output logic            misalign
);

  localparam int unsigned     CNT_W    = $clog2(RESOLVE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESOLVE_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INC      = XLEN'(4);

  typedef enum logic {
    RUN,
    WAIT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] ip_q;
  logic [XLEN-1:0] br_pc;
  logic [CNT_W-1:0] cnt;

  logic            cf;
  logic [XLEN-1:0] tgt_taken;
  logic [XLEN-1:0] tgt_next;

  always_comb begin
    cf        = (OP == 7'b1101111) || (OP == 7'b1100111) || (OP == 7'b1100011);
    tgt_taken = br_pc + up_amt;
    tgt_next  = b_taken ? tgt_taken : (br_pc + INC);
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic mis_q;
  logic trap;

  // Only a taken target can be misaligned; the fall-through is always word aligned.
  always_comb begin
    trap = b_taken && (tgt_taken[1:0] != 2'b00);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= RUN;
      ip_q  <= RESET_VECTOR;
      br_pc <= '0;
      cnt   <= '0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (!hold) begin
        unique case (state)
          RUN: begin
            if (cf) begin
              br_pc <= ip_q;
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end else begin
              ip_q <= ip_q + INC;
            end
          end
          WAIT: begin
            if (cnt != CNT_ONE) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              cnt   <= '0;
              state <= RUN;
              if (trap) begin
                ip_q  <= TRAP_VECTOR;
                mis_q <= 1'b1;
              end else begin
                ip_q <= tgt_next;
              end
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign misalign = mis_q;
`else
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= RUN;
      ip_q  <= RESET_VECTOR;
      br_pc <= '0;
      cnt   <= '0;
    end else if (!hold) begin
      unique case (state)
        RUN: begin
          if (cf) begin
            br_pc <= ip_q;
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end else begin
            ip_q <= ip_q + INC;
          end
        end
        WAIT: begin
          if (cnt != CNT_ONE) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt   <= '0;
            state <= RUN;
            ip_q  <= tgt_next;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign misalign = 1'b0;
`endif

  assign IP          = ip_q;
  assign PC_def      = ip_q + INC;
  assign fetch_valid = (state == RUN);
  assign busy        = (state == WAIT);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Random and directed bench for pc_seq_unit; three instances with RESOLVE_LAT 1, 2, 3 share stimulus.
module tb_pc_seq_unit;

  localparam logic [31:0] RV   = 32'h0;
  localparam logic [31:0] TRAP = 32'h100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic        hold;
  logic [6:0]  OP;
  logic        b_taken;
  logic [31:0] up_amt;

  logic [31:0] ip  [3];
  logic [31:0] pcd [3];
  logic        fv  [3];
  logic        bsy [3];
  logic        mis [3];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference state: remaining bubbles (0 = fetching), branch base, current address.
  logic [31:0] m_ip   [3];
  logic [31:0] m_base [3];
  int unsigned m_wait [3];
  logic        m_mis  [3];
  int unsigned lat    [3];

  pc_seq_unit #(.XLEN(32), .RESET_VECTOR(RV), .RESOLVE_LAT(1), .TRAP_VECTOR(TRAP)) u_lat1 (
    .CLK(CLK), .RESET(RESET), .hold(hold), .OP(OP), .b_taken(b_taken), .up_amt(up_amt),
    .IP(ip[0]), .PC_def(pcd[0]), .fetch_valid(fv[0]), .busy(bsy[0]), .misalign(mis[0]));

  pc_seq_unit #(.XLEN(32), .RESET_VECTOR(RV), .RESOLVE_LAT(2), .TRAP_VECTOR(TRAP)) u_lat2 (
    .CLK(CLK), .RESET(RESET), .hold(hold), .OP(OP), .b_taken(b_taken), .up_amt(up_amt),
    .IP(ip[1]), .PC_def(pcd[1]), .fetch_valid(fv[1]), .busy(bsy[1]), .misalign(mis[1]));

  pc_seq_unit #(.XLEN(32), .RESET_VECTOR(RV), .RESOLVE_LAT(3), .TRAP_VECTOR(TRAP)) u_lat3 (
    .CLK(CLK), .RESET(RESET), .hold(hold), .OP(OP), .b_taken(b_taken), .up_amt(up_amt),
    .IP(ip[2]), .PC_def(pcd[2]), .fetch_valid(fv[2]), .busy(bsy[2]), .misalign(mis[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_cf(input logic [6:0] op);
    return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ip[i]   = RV;
      m_base[i] = 32'h0;
      m_wait[i] = 0;
      m_mis[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    for (int i = 0; i < 3; i++) begin
      m_mis[i] = 1'b0;
      if (hold) begin
        // everything frozen
      end else if (m_wait[i] == 0) begin
        if (is_cf(OP)) begin
          m_base[i] = m_ip[i];
          m_wait[i] = lat[i];
        end else begin
          m_ip[i] = m_ip[i] + 32'd4;
        end
      end else if (m_wait[i] > 1) begin
        m_wait[i] = m_wait[i] - 1;
      end else begin
        tgt = b_taken ? (m_base[i] + up_amt) : (m_base[i] + 32'd4);
        m_wait[i] = 0;
        if (TRAP_ON && b_taken && (tgt[1:0] != 2'b00)) begin
          m_ip[i]  = TRAP;
          m_mis[i] = 1'b1;
        end else begin
          m_ip[i] = tgt;
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_ip%0d", where, i), ip[i], m_ip[i]);
      check($sformatf("%s_pcdef%0d", where, i), pcd[i], m_ip[i] + 32'd4);
      check($sformatf("%s_flags%0d", where, i), 32'({fv[i], bsy[i], mis[i]}),
            32'({m_wait[i] == 0, m_wait[i] != 0, m_mis[i]}));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all("step");
  endtask

  // Reset is raised between clock edges so its effect must be immediate.
  task automatic do_reset();
    RESET = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ip%0d", i), ip[i], RV);
      check($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst_mis%0d", i), 32'(mis[i]), 32'd0);
    end
    @(negedge CLK);
    hold    = 1'b0;
    OP      = 7'h13;
    b_taken = 1'b0;
    up_amt  = '0;
    RESET   = 1'b0;
    model_reset();
    #1;
    compare_all("rel");
  endtask

  task automatic nops(input int n);
    OP   = 7'h13;
    hold = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int lowc;
    lat[0] = 1; lat[1] = 2; lat[2] = 3;
    RESET = 1'b1; hold = 1'b0; OP = 7'h13; b_taken = 1'b0; up_amt = '0;
    model_reset();
    #2;
    do_reset();

    // Straight-line fetch
    check("t1_ip_start", ip[0], 32'h0);
    for (int k = 1; k <= 4; k++) begin
      nops(1);
      check($sformatf("t1_ip_k%0d", k), ip[0], 32'(k * 4));
      check($sformatf("t1_pcdef_k%0d", k), pcd[0], 32'(k * 4 + 4));
      check($sformatf("t1_fv_k%0d", k), 32'(fv[0]), 32'd1);
    end

    // Backward taken branch, latency 1 and 3
    do_reset();
    nops(8);
    check("t2_ip_pre", ip[0], 32'h20);
    OP = 7'h63; b_taken = 1'b1; up_amt = 32'hFFFF_FFF0;
    step();
    check("t2_ip_wait", ip[0], 32'h20);
    check("t2_busy_wait", 32'(bsy[0]), 32'd1);
    OP = 7'h13;
    step();
    check("t2_ip_tgt", ip[0], 32'h10);
    check("t2_busy_done", 32'(bsy[0]), 32'd0);
    step(); step();
    check("t2_ip_tgt_lat3", ip[2], 32'h10);

    // Not-taken JAL, latency 3
    do_reset();
    nops(16);
    OP = 7'h6F; b_taken = 1'b0; up_amt = 32'h0000_0800;
    lowc = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      OP = 7'h13;
      if (!fv[2]) lowc++;
      if (k <= 3) check($sformatf("t3_ip_held_k%0d", k), ip[2], 32'h40);
      if (k == 4) check("t3_ip_fall", ip[2], 32'h44);
    end
    check("t3_bubbles", 32'(lowc), 32'd3);

    // Hold inside WAIT, latency 2
    do_reset();
    nops(64);
    OP = 7'h63; b_taken = 1'b1; up_amt = 32'd8;
    lowc = 0;
    step(); if (!fv[1]) lowc++;
    OP = 7'h13; hold = 1'b1;
    step(); if (!fv[1]) lowc++;
    step(); if (!fv[1]) lowc++;
    hold = 1'b0;
    step(); if (!fv[1]) lowc++;
    step(); if (!fv[1]) lowc++;
    check("t4_bubbles", 32'(lowc), 32'd4);
    check("t4_ip_tgt", ip[1], 32'h108);

    // Reset mid-WAIT must discard the pending redirect
    do_reset();
    nops(32);
    OP = 7'h67; b_taken = 1'b1; up_amt = 32'h0000_4000;
    step();
    OP = 7'h13;
    step();
    check("t5_busy_pre", 32'(bsy[2]), 32'd1);
    do_reset();
    check("t5_ip_rst", ip[2], RV);
    nops(4);
    check("t5_ip_after", ip[2], 32'h10);

    // Misaligned taken target
    do_reset();
    nops(128);
    OP = 7'h63; b_taken = 1'b1; up_amt = 32'd6;
    step();
    OP = 7'h13;
    step();
    check("t6_ip", ip[0], TRAP_ON ? TRAP : 32'h206);
    check("t6_mis", 32'(mis[0]), 32'(TRAP_ON));
    step();
    check("t6_mis_clear", 32'(mis[0]), 32'd0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0: OP = 7'h6F;
        1: OP = 7'h67;
        2: OP = 7'h63;
        default: OP = 7'($urandom);
      endcase
      hold    = ($urandom_range(0, 4) == 0);
      b_taken = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      case (r)
        0, 1: up_amt = 32'($urandom_range(0, 63) * 4) - 32'd128;
        2:    up_amt = 32'($urandom_range(0, 255)) - 32'd128;
        default: up_amt = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
